moder_intra_nxn: RTL and testbench
==================================

MODER_INTRA_NXN -- requirements
Module: moder_intra_nxn

Interface
REQ-001 SHALL have parameter BLK, default 16, block edge in pixels; legal values 4, 8, 16.
REQ-002 SHALL have parameter BD, default 8, bits per pixel sample.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port mode  input  2  prediction mode: 0 vertical, 1 horizontal, 2 DC, 3 reserved.
REQ-007 SHALL have port top_avail  input  1  top neighbours valid.
REQ-008 SHALL have port left_avail  input  1  left neighbours valid.
REQ-009 SHALL have port toppixels  input  BLK*BD  top neighbour i at bits [i*BD +: BD].
REQ-010 SHALL have port leftpixels  input  BLK*BD  left neighbour i (row i) at bits [i*BD +: BD].
REQ-011 SHALL have port out_valid  output  1  out_row holds a valid prediction row.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the row.
REQ-013 SHALL have port out_row  output  BLK*BD  predicted row; column c at bits [c*BD +: BD].
REQ-014 SHALL have port out_rowidx  output  clog2(BLK)  index of the row on out_row.
REQ-015 SHALL have port out_last  output  1  high with out_valid on row BLK-1.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the last row is accepted.
REQ-018 SHALL have port err  output  1  one-cycle pulse on a rejected request.

Function
REQ-019 SHALL implement FSM states IDLE, SUM, OUT.
REQ-020 In IDLE with start=1 at edge T, SHALL register mode, availability flags, toppixels and leftpixels; inputs are ignored after T.
REQ-021 Request SHALL be rejected (err=1 in cycle T+1, stay IDLE, no rows emitted) when mode=3, when mode=0 and top_avail=0, or when mode=1 and left_avail=0.
REQ-022 Accepted V/H request SHALL go IDLE->OUT, with out_valid high from cycle T+1.
REQ-023 Accepted DC request SHALL go IDLE->SUM, accumulating top[k] (if top_avail) plus left[k] (if left_avail) in cycle k, k=0..BLK-1, then ->OUT; out_valid high from cycle T+BLK+1.
REQ-024 Accumulator SHALL be BD+clog2(BLK)+1 bits wide and SHALL never overflow.
REQ-025 DC value SHALL be (sum+BLK)>>(log2(BLK)+1) with both flags set; (sum+BLK/2)>>log2(BLK) with one flag set; 1<<(BD-1) with neither set; the result fits in BD bits.
REQ-026 Vertical row r SHALL equal the top row for every r; horizontal row r SHALL have every column equal to left[r]; DC rows SHALL have every column equal to the DC value.
REQ-027 In OUT, a row SHALL be transferred when out_valid and out_ready are both high; out_rowidx then increments, starting from 0.
REQ-028 While out_valid=1 and out_ready=0, out_row, out_rowidx and out_last SHALL hold stable.
REQ-029 On transfer of row BLK-1, SHALL return to IDLE, drop out_valid and pulse done in the following cycle.
REQ-030 start while busy=1 SHALL be ignored: no capture, no err.
REQ-031 A new start is accepted in the cycle done is high (IDLE), giving back-to-back blocks.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE and clear accumulator and row counter.
REQ-033 reset SHALL drive out_valid, out_row, out_rowidx, out_last, busy, done and err to 0.
REQ-034 reset asserted mid-SUM or mid-OUT SHALL abort the block; no done pulse follows.
REQ-035 reset SHALL take priority over start in the same cycle.

Verification
REQ-036 BLK=16, DC, both flags, top all 10, left all 20 -> 16 rows of value 15 (496>>5); out_valid first at T+17.
REQ-037 BLK=16, DC, top only, top=0..15 -> value 8; neither flag -> value 128; BLK=4, both flags, top=1,2,3,4 and left=5,6,7,8 -> value 5.
REQ-038 BLK=16, vertical, top[i]=i, out_ready low for 3 cycles at row 5 -> row 5 held stable; every row is 0..15; done pulses once after row 15.
REQ-039 Horizontal with left_avail=0, or mode=3 -> single err pulse at T+1, out_valid never high, busy stays 0.
REQ-040 reset at row 7 of a DC block -> all outputs 0 next cycle; a subsequent vertical request completes correctly.
REQ-041 start held high through a block plus a new start in the done cycle -> exactly two blocks emitted, with no extra err.

Source files
------------

// File: rtl/moder_intra_nxn.sv
// moder_intra_nxn: NxN intra predictor (vertical, horizontal, DC) streaming one row per handshake.
module moder_intra_nxn #(
  parameter int BLK = 16,
  parameter int BD  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    top_avail,
  input  logic                    left_avail,
  input  logic [BLK*BD-1:0]       toppixels,
  input  logic [BLK*BD-1:0]       leftpixels,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLK*BD-1:0]       out_row,
  output logic [$clog2(BLK)-1:0]  out_rowidx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int CW = $clog2(BLK);
  localparam int AW = BD + CW + 1;
  localparam logic [CW-1:0] LAST = CW'(BLK - 1);
  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [1:0] mode_q;
  logic ta_q, la_q, err_q, err_d, done_q, done_d, bad;
  logic [BLK*BD-1:0] tp_q, lp_q, row;
  logic [BD-1:0] dc, lft;
  assign bad = mode == 2'd3 || (mode == 2'd0 && !top_avail) || (mode == 2'd1 && !left_avail);
  assign lft = lp_q[cnt_q*BD +: BD];
  assign dc = ta_q && la_q ? BD'((acc_q + AW'(BLK)) >> (CW + 1)) :
              ta_q || la_q ? BD'((acc_q + AW'(BLK / 2)) >> CW) : BD'(1 << (BD - 1));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    err_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        err_d = bad;
        state_d = bad ? IDLE : mode == 2'd2 ? SUM : OUT;
        cnt_d = '0;
        acc_d = '0;
      end
      SUM: begin
        acc_d = acc_q + AW'(tp_q[cnt_q*BD +: BD] & {BD{ta_q}}) + AW'(lp_q[cnt_q*BD +: BD] & {BD{la_q}});
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? OUT : SUM;
      end
      OUT: if (out_ready) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? IDLE : OUT;
        done_d = cnt_q == LAST;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    row = '0;
    for (int c = 0; c < BLK; c++)
      row[c*BD +: BD] = mode_q == 2'd0 ? tp_q[c*BD +: BD] : mode_q == 2'd1 ? lft : dc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  // Operands are frozen at acceptance so the producer may change them mid-block.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      mode_q <= mode;
      ta_q <= top_avail;
      la_q <= left_avail;
      tp_q <= toppixels;
      lp_q <= leftpixels;
    end
  end
  assign out_valid = state_q == OUT;
  assign out_row = out_valid ? row : '0;
  assign out_rowidx = out_valid ? cnt_q : '0;
  assign out_last = out_valid && cnt_q == LAST;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_moder_intra_nxn.sv
// tb_moder_intra_nxn: directed checks of the intra predictor at BLK=16 plus a BLK=4 DC case.
module tb_moder_intra_nxn;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, start = 1'b0, top_avail = 1'b0, left_avail = 1'b0, out_ready = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [127:0] toppixels = '0, leftpixels = '0, out_row;
  logic out_valid, out_last, busy, done, err;
  logic [3:0] out_rowidx;
  logic s_start = 1'b0, s_valid, s_last, s_busy, s_done, s_err;
  logic [31:0] s_top = '0, s_left = '0, s_row;
  logic [1:0] s_idx;
  int checks = 0, errors = 0, cyc = 0;
  int lat, errlat, nrows, ndone, nerr, nbusy, lastpos;
  logic idx_bad;
  logic [127:0] rows [16];

  moder_intra_nxn dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .top_avail(top_avail),
    .left_avail(left_avail), .toppixels(toppixels), .leftpixels(leftpixels),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_rowidx(out_rowidx),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );
  moder_intra_nxn #(.BLK(4), .BD(8)) dut4 (
    .clk(clk), .reset(reset), .start(s_start), .mode(2'd2), .top_avail(1'b1),
    .left_avail(1'b1), .toppixels(s_top), .leftpixels(s_left),
    .out_valid(s_valid), .out_ready(1'b1), .out_row(s_row), .out_rowidx(s_idx),
    .out_last(s_last), .busy(s_busy), .done(s_done), .err(s_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rep(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] ramp(input int mul);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(i * mul);
    return r;
  endfunction

  task automatic run_block(input logic [1:0] m, input logic t_a, input logic l_a, input logic [127:0] t, input logic [127:0] l);
    int c0;
    @(negedge clk);
    mode = m; top_avail = t_a; left_avail = l_a; toppixels = t; leftpixels = l; start = 1'b1; out_ready = 1'b1;
    c0 = cyc;
    lat = -1; errlat = -1; nrows = 0; ndone = 0; nerr = 0; nbusy = 0; lastpos = -1; idx_bad = 1'b0;
    @(negedge clk);
    start = 1'b0; toppixels = ~t; leftpixels = ~l;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        if (lat < 0) lat = cyc - c0;
        if (out_last) lastpos = nrows;
        if (out_rowidx !== 4'(nrows)) idx_bad = 1'b1;
        if (nrows < 16) rows[nrows] = out_row;
        nrows++;
      end
      if (err) begin
        nerr++;
        if (errlat < 0) errlat = cyc - c0;
      end
      if (done) ndone++;
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {out_valid, out_last, busy, done, err}); end
    checks++;
    if (out_row !== '0 || out_rowidx !== 4'd0) begin errors++; $display("FAIL reset_row got %h/%0d exp 0/0", out_row, out_rowidx); end
    reset = 1'b0;
  endtask

  task automatic test_dc_both;
    run_block(2'd2, 1'b1, 1'b1, rep(8'd10), rep(8'd20));
    checks++;
    if (lat != 17) begin errors++; $display("FAIL dc_latency got %0d exp 17", lat); end
    checks++;
    if (nrows != 16) begin errors++; $display("FAIL dc_rows got %0d exp 16", nrows); end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (rows[r] !== rep(8'd15)) begin errors++; $display("FAIL dc_row%0d got %h exp %h", r, rows[r], rep(8'd15)); end
    end
    checks++;
    if (lastpos != 15 || idx_bad) begin errors++; $display("FAIL dc_last_idx got last %0d idxbad %0d exp 15 0", lastpos, idx_bad); end
    checks++;
    if (ndone != 1 || nerr != 0) begin errors++; $display("FAIL dc_done_err got %0d %0d exp 1 0", ndone, nerr); end
  endtask

  task automatic test_dc_single;
    run_block(2'd2, 1'b1, 1'b0, ramp(1), rep(8'd99));
    checks++;
    if (nrows != 16 || rows[0] !== rep(8'd8) || rows[15] !== rep(8'd8)) begin errors++; $display("FAIL dc_top_only got %0d rows %h exp 16 %h", nrows, rows[0], rep(8'd8)); end
    run_block(2'd2, 1'b0, 1'b1, rep(8'd50), rep(8'd7));
    checks++;
    if (nrows != 16 || rows[3] !== rep(8'd7)) begin errors++; $display("FAIL dc_left_only got %0d rows %h exp 16 %h", nrows, rows[3], rep(8'd7)); end
    run_block(2'd2, 1'b0, 1'b0, rep(8'd1), rep(8'd2));
    checks++;
    if (nrows != 16 || rows[9] !== rep(8'd128)) begin errors++; $display("FAIL dc_none got %0d rows %h exp 16 %h", nrows, rows[9], rep(8'd128)); end
  endtask

  task automatic test_dc_blk4;
    int c0, n, nd, l4;
    @(negedge clk);
    s_top = {8'd4, 8'd3, 8'd2, 8'd1}; s_left = {8'd8, 8'd7, 8'd6, 8'd5}; s_start = 1'b1; c0 = cyc;
    @(negedge clk);
    s_start = 1'b0; n = 0; nd = 0; l4 = -1;
    for (int i = 0; i < 20; i++) begin
      if (s_valid) begin
        if (l4 < 0) l4 = cyc - c0;
        checks++;
        if (s_row !== {4{8'd5}} || s_idx !== 2'(n)) begin errors++; $display("FAIL blk4_row%0d got %h/%0d exp %h", n, s_row, s_idx, {4{8'd5}}); end
        n++;
      end
      if (s_done) nd++;
      @(negedge clk);
    end
    checks++;
    if (l4 != 5 || n != 4 || nd != 1) begin errors++; $display("FAIL blk4_seq got lat %0d rows %0d done %0d exp 5 4 1", l4, n, nd); end
  endtask

  task automatic test_vertical_stall;
    int st, n, nd;
    logic [127:0] snap;
    @(negedge clk);
    mode = 2'd0; top_avail = 1'b1; left_avail = 1'b0; toppixels = ramp(1); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; toppixels = '1; st = 0; n = 0; nd = 0; snap = '0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_rowidx == 4'd5 && st < 3) begin
        if (st == 0) snap = out_row;
        else begin
          checks++;
          if (out_row !== snap || out_rowidx !== 4'd5 || out_last) begin errors++; $display("FAIL stall_hold got %h/%0d exp %h/5", out_row, out_rowidx, snap); end
        end
        out_ready = 1'b0;
        st++;
      end else if (out_valid) begin
        out_ready = 1'b1;
        checks++;
        if (out_row !== ramp(1) || out_rowidx !== 4'(n)) begin errors++; $display("FAIL vert_row%0d got %h/%0d exp %h", n, out_row, out_rowidx, ramp(1)); end
        n++;
      end else out_ready = 1'b1;
      if (done) nd++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (n != 16 || nd != 1 || st != 3) begin errors++; $display("FAIL vert_seq got rows %0d done %0d stalls %0d exp 16 1 3", n, nd, st); end
  endtask

  task automatic test_horizontal;
    run_block(2'd1, 1'b0, 1'b1, rep(8'd77), ramp(3));
    checks++;
    if (lat != 1 || nrows != 16 || ndone != 1) begin errors++; $display("FAIL horiz_seq got %0d %0d %0d exp 1 16 1", lat, nrows, ndone); end
    for (int r = 0; r < 16; r += 5) begin
      checks++;
      if (rows[r] !== rep(8'(3 * r))) begin errors++; $display("FAIL horiz_row%0d got %h exp %h", r, rows[r], rep(8'(3 * r))); end
    end
  endtask

  task automatic test_reject;
    run_block(2'd1, 1'b1, 1'b0, ramp(1), ramp(2));
    checks++;
    if (errlat != 1 || nerr != 1 || nrows != 0 || nbusy != 0) begin errors++; $display("FAIL reject_h got %0d %0d %0d %0d exp 1 1 0 0", errlat, nerr, nrows, nbusy); end
    run_block(2'd3, 1'b1, 1'b1, ramp(1), ramp(2));
    checks++;
    if (errlat != 1 || nerr != 1 || nrows != 0 || nbusy != 0) begin errors++; $display("FAIL reject_m3 got %0d %0d %0d %0d exp 1 1 0 0", errlat, nerr, nrows, nbusy); end
  endtask

  task automatic test_reset_mid;
    int k, nd;
    @(negedge clk);
    mode = 2'd2; top_avail = 1'b1; left_avail = 1'b1; toppixels = rep(8'd1); leftpixels = rep(8'd2); start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    while (!(out_valid && out_rowidx == 4'd7) && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 40) begin errors++; $display("FAIL rst_reach_row7 got timeout exp row 7"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0 || out_row !== '0 || out_rowidx !== 4'd0) begin errors++; $display("FAIL rst_mid got %b %h %0d exp all 0", {out_valid, out_last, busy, done, err}, out_row, out_rowidx); end
    reset = 1'b0; nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || out_valid) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", nd); end
    run_block(2'd0, 1'b1, 1'b0, ramp(1), rep(8'd0));
    checks++;
    if (nrows != 16 || ndone != 1 || rows[7] !== ramp(1) || rows[15] !== ramp(1)) begin errors++; $display("FAIL rst_after_vert got %0d %0d %h exp 16 1 %h", nrows, ndone, rows[7], ramp(1)); end
  endtask

  task automatic test_back_to_back;
    int n, nd, ne, bad;
    @(negedge clk);
    mode = 2'd0; top_avail = 1'b1; left_avail = 1'b0; toppixels = ramp(1); start = 1'b1; out_ready = 1'b1;
    n = 0; nd = 0; ne = 0; bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n++;
        if (out_row !== ramp(1)) bad++;
      end
      if (err) ne++;
      if (done) nd++;
      if (nd == 2) start = 1'b0;
      toppixels = busy ? ~ramp(1) : ramp(1);
    end
    start = 1'b0;
    checks++;
    if (n != 32 || bad != 0 || nd != 2 || ne != 0) begin errors++; $display("FAIL b2b got rows %0d bad %0d done %0d err %0d exp 32 0 2 0", n, bad, nd, ne); end
  endtask

  initial begin
    test_reset;
    test_dc_both;
    test_dc_single;
    test_dc_blk4;
    test_vertical_stall;
    test_horizontal;
    test_reject;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
